// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard / forwarding controller for the rv32 pipeline (FE/DE/EXE/ACC/WB).
//   Resolves the DE source operands against the results still in flight in
//   EXE, ACC and WB, resolves EXE branches/jumps (pc_sel), and runs a small
//   stall/flush FSM that holds or kills the front end.
//
//   Optional feature: define HZD_PERF_CNT_EN to add saturating performance
//   counters (stall_cnt, flush_cnt, fwd_cnt).
//
//   Handshake / timing contract: there is no valid/ready pairing here. All
//   valid_* inputs qualify their stage's instruction in the same cycle;
//   data_mgr, hazard and pc_sel are combinational (zero latency); stall and
//   flush are combinational functions of the registered FSM state plus the
//   current load_use / pc_sel terms.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   instr_de, data_de           DE instruction and register-file read data
//   instr_exe/valid_exe         EXE instruction, alu_out_exe, pc_exe
//   instr_acc/valid_acc         ACC instruction, alu_out_acc, dmem_out_acc,
//                               pc_4_acc
//   instr_wb/valid_wb           WB instruction, data_d_wb
//   br_a_exe, br_b_exe          EXE branch compare operands
//   data_mgr, hazard            resolved DE operands, per-operand forward flag
//   stall, flush, pc_sel        front-end hold, front-end kill, redirect
//   stall_cnt, flush_cnt,
//   fwd_cnt                     perf counters (HZD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
   parameter int XLEN       = 32,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_STALL = 1,
   parameter int FLUSH_CYC  = 2,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             instr_de,
   input  logic [NUM_SRC*XLEN-1:0] data_de,
   input  logic [31:0]             instr_exe,
   input  logic                    valid_exe,
   input  logic [XLEN-1:0]         alu_out_exe,
   input  logic [XLEN-1:0]         pc_exe,
   input  logic [31:0]             instr_acc,
   input  logic                    valid_acc,
   input  logic [XLEN-1:0]         alu_out_acc,
   input  logic [XLEN-1:0]         dmem_out_acc,
   input  logic [XLEN-1:0]         pc_4_acc,
   input  logic [31:0]             instr_wb,
   input  logic                    valid_wb,
   input  logic [XLEN-1:0]         data_d_wb,
   input  logic [XLEN-1:0]         br_a_exe,
   input  logic [XLEN-1:0]         br_b_exe,
   output logic [NUM_SRC*XLEN-1:0] data_mgr,
   output logic [NUM_SRC-1:0]      hazard,
`ifdef HZD_PERF_CNT_EN
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        flush_cnt,
   output logic [CNT_W-1:0]        fwd_cnt,
`endif
   output logic                    stall,
   output logic                    flush,
   output logic                    pc_sel
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam int CNT_MAX = (LOAD_STALL > FLUSH_CYC) ? LOAD_STALL : FLUSH_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYC - 1);
   localparam logic [CW-1:0] STALL_RELOAD = CW'(LOAD_STALL - 1);

   typedef enum logic [1:0] {WC_NONE, WC_ALU, WC_PC4, WC_DMEM} wclass_t;
   typedef enum logic [1:0] {S_IDLE, S_STALL, S_FLUSH} state_t;

   function automatic wclass_t writer_class(input logic [31:0] instr);
      case (instr[6:0])
         OP_LUI, OP_AUIPC, OP_OP, OP_IMM: return WC_ALU;
         OP_JAL, OP_JALR:                 return WC_PC4;
         OP_LOAD:                         return WC_DMEM;
         default:                         return WC_NONE;
      endcase
   endfunction

   // Operand k reads rs1, rs2 or rs3 ([31:27]).
   function automatic logic [4:0] rs_field(input logic [31:0] instr, input int k);
      case (k)
         0:       return instr[19:15];
         1:       return instr[24:20];
         default: return instr[31:27];
      endcase
   endfunction

   wclass_t exe_cls, acc_cls, wb_cls;
   logic    exe_live, acc_live, wb_live;
   logic    de_uses;
   logic    load_use;
   logic [XLEN-1:0] exe_val, acc_val;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic            unused_bits;

   assign exe_cls = writer_class(instr_exe);
   assign acc_cls = writer_class(instr_acc);
   assign wb_cls  = writer_class(instr_wb);

   // A stage is a forwarding candidate only if it really writes a non-x0 rd.
   assign exe_live = valid_exe && (exe_cls != WC_NONE) && (instr_exe[11:7] != 5'd0);
   assign acc_live = valid_acc && (acc_cls != WC_NONE) && (instr_acc[11:7] != 5'd0);
   assign wb_live  = valid_wb  && (wb_cls  != WC_NONE) && (instr_wb[11:7]  != 5'd0);

   // U-type and J-type instructions read no registers, so they cannot suffer a
   // load-use hazard.
   assign de_uses = !((instr_de[6:0] == OP_LUI) || (instr_de[6:0] == OP_AUIPC) ||
                      (instr_de[6:0] == OP_JAL));

   // An EXE load has no data yet; the value driven for it is ignored because
   // the FSM stalls DE until the load reaches ACC.
   assign exe_val = (exe_cls == WC_PC4) ? pc_exe + XLEN'(4) : alu_out_exe;

   always_comb begin
      case (acc_cls)
         WC_PC4:  acc_val = pc_4_acc;
         WC_DMEM: acc_val = dmem_out_acc;
         default: acc_val = alu_out_acc;
      endcase
   end

   // Per-operand forwarding mux, youngest producer first.
   always_comb begin
      data_mgr = data_de;
      hazard   = '0;
      load_use = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (exe_live && (instr_exe[11:7] == rs_field(instr_de, k))) begin
            hazard[k] = 1'b1;
            data_mgr[k*XLEN +: XLEN] = exe_val;
            if ((exe_cls == WC_DMEM) && de_uses) load_use = 1'b1;
         end else if (acc_live && (instr_acc[11:7] == rs_field(instr_de, k))) begin
            hazard[k] = 1'b1;
            data_mgr[k*XLEN +: XLEN] = acc_val;
         end else if (wb_live && (instr_wb[11:7] == rs_field(instr_de, k))) begin
            hazard[k] = 1'b1;
            data_mgr[k*XLEN +: XLEN] = data_d_wb;
         end
      end
   end

   // Branch / jump resolution in EXE.
   always_comb begin
      pc_sel = 1'b0;
      if (valid_exe) begin
         case (instr_exe[6:0])
            OP_JAL, OP_JALR: pc_sel = 1'b1;
            OP_BRANCH: begin
               case (instr_exe[14:12])
                  3'b000:  pc_sel = (br_a_exe == br_b_exe);
                  3'b001:  pc_sel = (br_a_exe != br_b_exe);
                  3'b100:  pc_sel = ($signed(br_a_exe) <  $signed(br_b_exe));
                  3'b101:  pc_sel = ($signed(br_a_exe) >= $signed(br_b_exe));
                  3'b110:  pc_sel = (br_a_exe <  br_b_exe);
                  3'b111:  pc_sel = (br_a_exe >= br_b_exe);
                  default: pc_sel = 1'b0;
               endcase
            end
            default: pc_sel = 1'b0;
         endcase
      end
   end

   // Stall/flush FSM. cnt holds the remaining extra cycles in STALL/FLUSH; a
   // redirect always wins over a pending stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pc_sel) begin
                  state <= S_FLUSH;
                  cnt   <= FLUSH_RELOAD;
               end else if (load_use) begin
                  state <= S_STALL;
                  cnt   <= STALL_RELOAD;
               end
            end
            S_STALL: begin
               if (pc_sel) begin
                  state <= S_FLUSH;
                  cnt   <= FLUSH_RELOAD;
               end else if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_FLUSH: begin
               if (pc_sel) begin
                  cnt <= FLUSH_RELOAD;
               end else if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // flush dominates, so stall is masked whenever flush is asserted.
   assign flush = (state == S_FLUSH) || pc_sel;
   assign stall = !flush && ((state == S_STALL) || ((state == S_IDLE) && load_use));

`ifdef HZD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall && !(&stall_cnt))   stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && !(&flush_cnt))   flush_cnt <= flush_cnt + CNT_W'(1);
         if ((|hazard) && !(&fwd_cnt)) fwd_cnt   <= fwd_cnt + CNT_W'(1);
      end
   end
   assign unused_bits = ^{instr_de, instr_exe, instr_acc, instr_wb};
`else
   assign unused_bits = ^{instr_de, instr_exe, instr_acc, instr_wb, CNT_W[0]};
`endif

endmodule
